axis_rate_limit: RTL
====================

Name: axis_rate_limit

Overview:
- AXI4-Stream rate limiter placed directly upstream of the pipeline FIFO stage.
- Throttles accepted beats to an average of rate_num beats per rate_denom cycles, using a credit accumulator.
- Optional frame mode only throttles at frame boundaries, so frames are never split by pauses.
- Output passes through a 2-entry skid register, so all output signals are registered.

Parameters:
- DATA_WIDTH, 8: tdata width in bits.
- KEEP_ENABLE, (DATA_WIDTH>8): propagate tkeep.
- KEEP_WIDTH, ((DATA_WIDTH+7)/8): tkeep width.
- LAST_ENABLE, 1: propagate tlast.
- ID_ENABLE, 0: propagate tid.
- ID_WIDTH, 8: tid width.
- DEST_ENABLE, 0: propagate tdest.
- DEST_WIDTH, 8: tdest width.
- USER_ENABLE, 1: propagate tuser.
- USER_WIDTH, 1: tuser width.
- ACC_WIDTH, 16: credit accumulator width; must be at least 10.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in (tready out)  per parameters  AXI input.
- m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out (tready in)  per parameters  AXI output.
- rate_num  in  8  beats allowed per window; 0 blocks all input.
- rate_denom  in  8  window length in cycles.
- rate_by_frame  in  1  1 = pause only between frames.

Behaviour:
- Reset is synchronous, active-high, on clk. While rst is high:
  - acc=0, in_frame=0.
  - m_axis_tvalid=0; skid register emptied.
  - s_axis_tready=0 during the reset cycle; it may rise on the first cycle after rst deasserts.
- Accepted beat: s_axis_tvalid && s_axis_tready.
- Effective numerator: num_eff = min(rate_num, rate_denom).
- Accumulator update, every cycle:
  - acc_next = acc + (beat ? rate_denom : 0) - num_eff.
  - Floor at 0; saturate at 2^ACC_WIDTH-1.
- Gate:
  - pass = (acc < num_eff) || (rate_by_frame && in_frame).
  - s_axis_tready = pass && out_ready_reg. Derived only from registers and the rate_* inputs; no combinational path from m_axis_tready.
- Frame tracking:
  - in_frame is set on an accepted beat with tlast=0.
  - in_frame is cleared on an accepted beat with tlast=1.
  - When LAST_ENABLE=0, every beat is treated as tlast=1.
- Rate outcomes:
  - num_eff = denom: full rate, acc stays 0.
  - rate_num = 0: s_axis_tready held 0, except that in frame mode an in-progress frame completes.
- Rate inputs are sampled every cycle. A change takes effect on the next acc evaluation; acc is not reset.
- Output stage: 2-entry skid.
  - Latency: accepted beat appears on m_axis one cycle later.
  - out_ready_reg is registered: 1 when the output reg is empty, when m_axis_tready=1, or when the skid slot is free.
  - No beat is lost or duplicated when m_axis_tready drops with tvalid high.
  - Order is preserved.
- m_axis outputs are stable while tvalid=1 and tready=0.
- Disabled fields are driven as constants:
  - tkeep all-ones; tlast=1.
  - tid, tdest, tuser = 0.
- Mid-frame reset: in_frame cleared; the partial frame is dropped from the output; upstream must restart the frame.

Decomposition:
- No shared package. Width defaults are local parameters, consistent with the stream-family parameter set.
- One natural sub-module: axis_skid_reg (generic 2-entry registered slice, same parameter set). It is reusable by neighbouring stream stages.
- The accumulator and frame tracker stay in the top module.

Test Plan:
- num=1, denom=2, tvalid held high for 20 cycles, m_axis_tready=1 -> exactly 10 beats accepted, alternating accept/pause; first output 1 cycle after first accept.
- num=2, denom=3, continuous input for 30 cycles -> 20 beats accepted in pattern accept, accept, pause; acc never exceeds 3.
- num=1, denom=4, rate_by_frame=1, 4-beat frames -> each frame passes in 4 consecutive cycles, followed by a 12-cycle pause before the next frame starts.
- num=denom=8, m_axis_tready toggled pseudo-randomly, 100 counting beats -> output sequence is 0..99 in order with no gaps or duplicates, and outputs are stable while stalled.
- rate_num=0 asserted mid-frame in frame mode -> remaining beats of the frame pass through; s_axis_tready is then 0 until rate_num=4 is restored.
- rst pulsed for 1 cycle mid-stream -> m_axis_tvalid=0 the following cycle, acc=0, and input accepted again from the second cycle after rst.

Source files
------------

// File: rtl/axis_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : axis_skid_reg
// Purpose  : Two-entry AXI4-Stream register slice with a registered tready.
// Revision : 1.0
// ============================================================================
module axis_skid_reg #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
    parameter int LAST_ENABLE = 1,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser
);

    localparam int c_PAYLOAD_W = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
    localparam logic [c_PAYLOAD_W-1:0] c_IDLE_PAYLOAD = {
        {DATA_WIDTH{1'b0}}, {KEEP_WIDTH{1'b1}}, 1'b1,
        {ID_WIDTH{1'b0}}, {DEST_WIDTH{1'b0}}, {USER_WIDTH{1'b0}}
    };

    logic [KEEP_WIDTH-1:0]  w_keep;
    logic                   w_last;
    logic [ID_WIDTH-1:0]    w_id;
    logic [DEST_WIDTH-1:0]  w_dest;
    logic [USER_WIDTH-1:0]  w_user;
    logic [c_PAYLOAD_W-1:0] w_in;

    logic                   m_valid_q, m_valid_d;
    logic [c_PAYLOAD_W-1:0] m_data_q, m_data_d;
    logic                   tmp_valid_q, tmp_valid_d;
    logic [c_PAYLOAD_W-1:0] tmp_data_q, tmp_data_d;
    logic                   s_ready_q, s_ready_d;

    // Disabled fields are forced to constants on entry, so the registers
    // only ever hold the constant value for them.
    assign w_keep = (KEEP_ENABLE != 0) ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};
    assign w_last = (LAST_ENABLE != 0) ? s_axis_tlast : 1'b1;
    assign w_id   = (ID_ENABLE   != 0) ? s_axis_tid   : {ID_WIDTH{1'b0}};
    assign w_dest = (DEST_ENABLE != 0) ? s_axis_tdest : {DEST_WIDTH{1'b0}};
    assign w_user = (USER_ENABLE != 0) ? s_axis_tuser : {USER_WIDTH{1'b0}};
    assign w_in   = {s_axis_tdata, w_keep, w_last, w_id, w_dest, w_user};

    always_comb begin
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        tmp_valid_d = tmp_valid_q;
        tmp_data_d  = tmp_data_q;
        // Stay ready next cycle if the sink drains, or if the skid slot is
        // guaranteed to remain free after this cycle.
        s_ready_d   = m_axis_tready || (!tmp_valid_q && (!m_valid_q || !s_axis_tvalid));

        if (s_ready_q) begin
            if (m_axis_tready || !m_valid_q) begin
                m_valid_d = s_axis_tvalid;
                m_data_d  = w_in;
            end else begin
                tmp_valid_d = s_axis_tvalid;
                tmp_data_d  = w_in;
            end
        end else if (m_axis_tready) begin
            m_valid_d   = tmp_valid_q;
            m_data_d    = tmp_data_q;
            tmp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q   <= 1'b0;
            m_data_q    <= c_IDLE_PAYLOAD;
            tmp_valid_q <= 1'b0;
            tmp_data_q  <= c_IDLE_PAYLOAD;
            s_ready_q   <= 1'b0;
        end else begin
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            tmp_valid_q <= tmp_valid_d;
            tmp_data_q  <= tmp_data_d;
            s_ready_q   <= s_ready_d;
        end
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_valid_q;
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast,
            m_axis_tid, m_axis_tdest, m_axis_tuser} = m_data_q;

endmodule
`default_nettype wire

// File: rtl/axis_rate_limit.sv
`default_nettype none
// ============================================================================
// Module   : axis_rate_limit
// Purpose  : Credit-based AXI4-Stream beat rate limiter with optional
//            frame-granular throttling and a registered output slice.
// Revision : 1.0
// ============================================================================
module axis_rate_limit #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
    parameter int LAST_ENABLE = 1,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    parameter int ACC_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,

    input  logic [7:0]            rate_num,
    input  logic [7:0]            rate_denom,
    input  logic                  rate_by_frame
);

    // Two guard bits: one for the +denom overshoot, one as the underflow sign.
    localparam int c_SUM_W = ACC_WIDTH + 2;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 in_frame_q, in_frame_d;

    logic [7:0]           w_num_eff;
    logic                 w_pass;
    logic                 w_out_ready;
    logic                 w_beat;
    logic                 w_last;
    logic [c_SUM_W-1:0]   w_sum;

    assign w_num_eff = (rate_num < rate_denom) ? rate_num : rate_denom;
    assign w_pass    = (acc_q < {{(ACC_WIDTH-8){1'b0}}, w_num_eff})
                     || (rate_by_frame && in_frame_q);

    assign s_axis_tready = w_pass && w_out_ready;
    assign w_beat        = s_axis_tvalid && s_axis_tready;
    assign w_last        = (LAST_ENABLE != 0) ? s_axis_tlast : 1'b1;

    assign w_sum = {2'b00, acc_q}
                 + (w_beat ? {{(c_SUM_W-8){1'b0}}, rate_denom} : {c_SUM_W{1'b0}})
                 - {{(c_SUM_W-8){1'b0}}, w_num_eff};

    always_comb begin
        acc_d      = w_sum[ACC_WIDTH-1:0];
        in_frame_d = in_frame_q;
        if (w_sum[c_SUM_W-1]) begin
            acc_d = {ACC_WIDTH{1'b0}};
        end else if (w_sum[ACC_WIDTH]) begin
            acc_d = {ACC_WIDTH{1'b1}};
        end
        if (w_beat) begin
            in_frame_d = !w_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= {ACC_WIDTH{1'b0}};
            in_frame_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            in_frame_q <= in_frame_d;
        end
    end

    axis_skid_reg #(
        .DATA_WIDTH  (DATA_WIDTH),
        .KEEP_ENABLE (KEEP_ENABLE),
        .KEEP_WIDTH  (KEEP_WIDTH),
        .LAST_ENABLE (LAST_ENABLE),
        .ID_ENABLE   (ID_ENABLE),
        .ID_WIDTH    (ID_WIDTH),
        .DEST_ENABLE (DEST_ENABLE),
        .DEST_WIDTH  (DEST_WIDTH),
        .USER_ENABLE (USER_ENABLE),
        .USER_WIDTH  (USER_WIDTH)
    ) u_skid (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid && w_pass),
        .s_axis_tready (w_out_ready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tuser  (m_axis_tuser)
    );

endmodule
`default_nettype wire
